// File: rtl/br_hazard_unit.sv
// br_hazard_unit: decode-stage branch operand forwarding select, load-use stall and stall counter
module br_hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             hold_i,
   input  logic             flush_i,
   input  logic             ID_valid_i,
   input  logic             ID_is_br_i,
   input  logic             ID_use_rs2_i,
   input  logic [4:0]       ID_rs1_addr_i,
   input  logic [4:0]       ID_rs2_addr_i,
   input  logic [4:0]       ID_rd_addr_i,
   input  logic             ID_rd_wren_i,
   input  logic             ID_is_load_i,
   output logic [1:0]       rs1_sel_o,
   output logic [1:0]       rs2_sel_o,
   output logic             stall_o,
   output logic [CNT_W-1:0] stall_cnt_o
);
   logic       ex_valid, ex_wren, ex_load, mem_valid, mem_wren, mem_load;
   logic [4:0] ex_rd, mem_rd;
   logic       act1, act2, exm1, exm2, memm1, memm2, haz1, haz2, adv;
   logic [1:0] sel1, sel2;

   // producer matching and select resolution; EX (youngest) wins over MEM, x0 never matches
   always_comb begin
      act1      = ID_valid_i & ID_is_br_i;
      act2      = act1 & ID_use_rs2_i;
      exm1      = ex_valid & ex_wren & (ex_rd == ID_rs1_addr_i) & (ID_rs1_addr_i != 5'd0);
      exm2      = ex_valid & ex_wren & (ex_rd == ID_rs2_addr_i) & (ID_rs2_addr_i != 5'd0);
      memm1     = mem_valid & mem_wren & (mem_rd == ID_rs1_addr_i) & (ID_rs1_addr_i != 5'd0);
      memm2     = mem_valid & mem_wren & (mem_rd == ID_rs2_addr_i) & (ID_rs2_addr_i != 5'd0);
      haz1      = act1 & exm1 & ex_load;
      haz2      = act2 & exm2 & ex_load;
      sel1      = !act1 ? 2'b00 : exm1 ? (ex_load ? 2'b00 : 2'b01) : memm1 ? (mem_load ? 2'b11 : 2'b10) : 2'b00;
      sel2      = !act2 ? 2'b00 : exm2 ? (ex_load ? 2'b00 : 2'b01) : memm2 ? (mem_load ? 2'b11 : 2'b10) : 2'b00;
      stall_o   = (haz1 | haz2) & ~flush_i;
      rs1_sel_o = stall_o ? 2'b00 : sel1;
      rs2_sel_o = stall_o ? 2'b00 : sel2;
      adv       = ID_valid_i & ~stall_o & ~flush_i;
   end

   // shadow pipeline: MEM takes EX, EX takes ID or a bubble; frozen while hold_i
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ex_valid  <= 1'b0;
         ex_wren   <= 1'b0;
         ex_load   <= 1'b0;
         ex_rd     <= 5'd0;
         mem_valid <= 1'b0;
         mem_wren  <= 1'b0;
         mem_load  <= 1'b0;
         mem_rd    <= 5'd0;
      end else if (!hold_i) begin
         mem_valid <= ex_valid;
         mem_wren  <= ex_wren;
         mem_load  <= ex_load;
         mem_rd    <= ex_rd;
         ex_valid  <= adv;
         ex_wren   <= adv & ID_rd_wren_i;
         ex_load   <= adv & ID_is_load_i;
         ex_rd     <= adv ? ID_rd_addr_i : 5'd0;
      end
   end

   // saturating stall-cycle counter, advances only on non-held stall cycles
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) stall_cnt_o <= '0;
      else if (!hold_i && stall_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
   end
endmodule

// File: doc/br_hazard_unit.md
Name: br_hazard_unit

Overview:
- Decode-stage hazard and forwarding controller for branch/JALR operands.
- Tracks destination-register info of instructions in EX and MEM through an internal two-entry shadow pipeline.
- Drives the 2-bit select of each branch-operand forwarding mux in ID, and asserts a one-cycle stall when a branch source is produced by a load still in EX.
- Counts stall cycles for performance monitoring.

Parameters:
- CNT_W, 16, width of saturating stall-cycle counter

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset, asynchronous, active-low
- hold_i  in  1  global pipeline freeze; all state holds
- flush_i  in  1  kill instruction in ID (taken branch/jump); bubble into EX
- ID_valid_i  in  1  ID holds a real instruction
- ID_is_br_i  in  1  ID instruction reads rs1 for branch compare/JALR target
- ID_use_rs2_i  in  1  ID instruction also compares rs2 (conditional branch)
- ID_rs1_addr_i  in  5  ID source 1
- ID_rs2_addr_i  in  5  ID source 2
- ID_rd_addr_i  in  5  ID destination
- ID_rd_wren_i  in  1  ID instruction writes rd
- ID_is_load_i  in  1  ID instruction is a load
- rs1_sel_o  out  2  00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data
- rs2_sel_o  out  2  same encoding for rs2
- stall_o  out  1  freeze PC and IF/ID, bubble into ID/EX
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst_ni low, asynchronous): EX/MEM shadow entries invalid (valid=0, wren=0, rd=0, load=0); stall_cnt_o=0.
- Outputs with no valid producers: selects 00, stall_o 0.
- Shadow advance on posedge when hold_i=0:
  - MEM <= EX.
  - EX <= ID fields when ID_valid_i=1, stall_o=0 and flush_i=0; otherwise EX <= bubble (valid=0).
- hold_i=1: EX, MEM and counter keep their values. Outputs stay combinational on the current state.
- Producer match for source s (combinational):
  - exm = EX.valid & EX.wren & EX.rd==s & s!=0.
  - memm is defined the same way on the MEM entry.
- Select per source:
  - Zero when ID_valid_i=0 or ID_is_br_i=0; rs2 also zero when ID_use_rs2_i=0.
  - Otherwise, in priority order: exm & EX.load -> load-use hazard; exm -> 01; memm & MEM.load -> 11; memm -> 10; else 00.
  - EX has priority over MEM (youngest producer wins).
- WB-stage producers are not tracked. The register file write-through bypass covers them.
- stall_o = hazard on rs1 or active rs2, AND flush_i=0.
  - While stall_o=1 both selects are forced to 00.
  - A load in EX moves to MEM next cycle, so the stall lasts exactly 1 cycle; the following cycle selects 11.
- flush_i=1: stall_o suppressed; selects don't-care but driven by the rules above.
- x0 never matches, even if a producer names rd=0 with wren=1.
- Counter: increments on each posedge where stall_o=1 and hold_i=0; saturates at all-ones, no wrap.
- Simultaneous hold_i and stall_o: stall_o stays asserted; no counter increment; state frozen.
- Reset mid-stall: stall_o deasserts immediately (shadow invalidated asynchronously).

Test Plan:
- ADD x5 in ID, next cycle BEQ x5,x0 in ID -> rs1_sel_o=01, rs2_sel_o=00, stall_o=0.
- LW x7, then BNE x1,x7 next cycle:
  - Cycle 1: stall_o=1, selects 00, stall_cnt_o 0->1.
  - Cycle 2: rs2_sel_o=11, stall_o=0.
- ADDI x3; NOP; BEQ x3,x3 -> rs1_sel_o=rs2_sel_o=10. Same pattern with LW x3 -> 11, no stall.
- ADD x4 (now in MEM) followed by SUB x4 (now in EX), then JALR x4 in ID -> rs1_sel_o=01 (EX priority); rs2 ignored (ID_use_rs2_i=0) -> 00.
- Edge and control cases:
  - Producer writes rd=0 then BEQ x0,x0 -> selects 00, no stall.
  - LW x9 then BEQ x9 with flush_i=1 -> stall_o=0, and EX becomes a bubble next cycle.
  - hold_i=1 for 3 cycles during a stall -> state and counter frozen.
- Counter with CNT_W=2: force 5 stall cycles -> stall_cnt_o saturates at 3. Assert rst_ni low mid-stall -> stall_o=0 and counter=0 immediately.
